// File: rtl/mac_seq.sv
// Operand sequencer for the mac block: clears the MAC, streams one operand pair per
// cycle into it, then captures {acc, of, len, trunc} onto a valid/ready result port.
module mac_seq #(
  parameter int DW      = 8,
  parameter int AW      = 16,
  parameter int MAX_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN+1)
) (
  input  logic          clk,
  input  logic          r_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_a,
  input  logic [DW-1:0] s_b,
  input  logic          s_last,
  output logic          mac_r,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  input  logic [AW-1:0] mac_acc,
  input  logic          mac_of,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_acc,
  output logic          m_of,
  output logic [LW-1:0] m_len,
  output logic          m_trunc
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_OUT} state_t;

  state_t        state, state_nx;
  logic [LW-1:0] cnt;
  logic          trunc;
  logic          hs;
  logic          at_max;

  assign hs     = s_valid & s_ready;
  assign at_max = (cnt == LW'(MAX_LEN-1));

  // Idle lanes feed zeros so a gap in the stream adds nothing to the accumulator.
  assign mac_a = hs ? s_a : '0;
  assign mac_b = hs ? s_b : '0;

  always_comb begin
    state_nx = state;
    mac_r    = 1'b0;
    s_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        mac_r = 1'b1;
        if (s_valid) state_nx = S_RUN;
      end
      S_RUN: begin
        s_ready = 1'b1;
        if (hs && (s_last || at_max)) state_nx = S_WAIT;
      end
      S_WAIT: state_nx = S_OUT;
      S_OUT:  if (m_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      cnt   <= '0;
      trunc <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt   <= '0;
          trunc <= 1'b0;
        end
        S_RUN: if (hs) begin
          cnt <= cnt + LW'(1);
          if (at_max && !s_last) trunc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // In WAIT the MAC has absorbed the final product, so its outputs are complete.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      m_valid <= 1'b0;
      m_acc   <= '0;
      m_of    <= 1'b0;
      m_len   <= '0;
      m_trunc <= 1'b0;
    end else begin
      if (state == S_WAIT) begin
        m_valid <= 1'b1;
        m_acc   <= mac_acc;
        m_of    <= mac_of;
        m_len   <= cnt;
        m_trunc <= trunc;
      end else if (state == S_OUT && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq with a behavioural 8x8 saturating MAC attached; directed vector
// table plus hand-written stall, truncation and mid-vector reset sequences.
module tb_mac_seq;
  localparam int DW = 8, AW = 16, MAX_LEN = 16, LW = $clog2(MAX_LEN+1);

  logic          clk = 0, r_n = 0;
  logic          s_valid = 0, s_ready, s_last = 0;
  logic [DW-1:0] s_a = 0, s_b = 0;
  logic          mac_r;
  logic [DW-1:0] mac_a, mac_b;
  logic [AW-1:0] mac_acc = 0;
  logic          mac_of = 0;
  logic          m_valid, m_ready = 1, m_of, m_trunc;
  logic [AW-1:0] m_acc;
  logic [LW-1:0] m_len;

  int total = 0, bad = 0;

  mac_seq #(.DW(DW), .AW(AW), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .r_n(r_n), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .s_last(s_last), .mac_r(mac_r), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
    .mac_of(mac_of), .m_valid(m_valid), .m_ready(m_ready), .m_acc(m_acc), .m_of(m_of),
    .m_len(m_len), .m_trunc(m_trunc)
  );

  always #5 clk = ~clk;

  // Reference MAC: sync clear, saturating accumulate, sticky overflow.
  logic [AW:0] sum;
  always_comb sum = {1'b0, mac_acc} + (17'(mac_a) * 17'(mac_b));
  always_ff @(posedge clk) begin
    if (mac_r) begin
      mac_acc <= '0;
      mac_of  <= 1'b0;
    end else if (sum[AW]) begin
      mac_acc <= '1;
      mac_of  <= 1'b1;
    end else begin
      mac_acc <= sum[AW-1:0];
    end
  end

  typedef struct { logic [AW-1:0] acc; logic of; logic [LW-1:0] len; logic trunc; } res_t;
  res_t rq[$];
  always @(posedge clk)
    if (r_n && m_valid && m_ready) rq.push_back('{m_acc, m_of, m_len, m_trunc});

  typedef struct {
    int n;
    int a[4];
    int b[4];
    int gap[4];
    int acc, of, len;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send_pair(input int a, input int b, input bit last, input int gap);
    int n;
    s_valid = 0;
    repeat (gap) @(negedge clk);
    s_a = DW'(a); s_b = DW'(b); s_last = last; s_valid = 1;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("s_ready timeout", 0, 1);
    @(negedge clk);
    s_valid = 0; s_last = 0;
  endtask

  task automatic get_result(input string name, input int acc, input int of,
                            input int len, input int trunc);
    int n;
    res_t r;
    n = 0;
    while (rq.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() == 0) begin
      chk({name, " result timeout"}, 0, 1);
      return;
    end
    r = rq.pop_front();
    chk({name, " acc"}, int'(r.acc), acc);
    chk({name, " of"}, int'(r.of), of);
    chk({name, " len"}, int'(r.len), len);
    chk({name, " trunc"}, int'(r.trunc), trunc);
  endtask

  initial begin
    int n;
    bit seen;
    tbl[0] = '{n:4, a:'{6,5,9,3},   b:'{9,4,2,8},   gap:'{0,0,0,0}, acc:116,   of:0, len:4};
    tbl[1] = '{n:2, a:'{255,40,0,0},b:'{255,40,0,0},gap:'{0,0,0,0}, acc:65535, of:1, len:2};
    tbl[2] = '{n:3, a:'{6,5,3,0},   b:'{7,5,11,0},  gap:'{0,0,0,0}, acc:100,   of:0, len:3};
    tbl[3] = '{n:4, a:'{6,5,9,3},   b:'{9,4,2,8},   gap:'{0,1,3,2}, acc:116,   of:0, len:4};

    // Reset state, with a pair offered so the mac_a gating is exercised.
    s_valid = 1; s_a = 8'd5; s_b = 8'd7;
    #2;
    chk("rst s_ready", s_ready, 0);
    chk("rst mac_r", mac_r, 1);
    chk("rst mac_a", mac_a, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst m_acc", m_acc, 0);
    chk("rst m_len", m_len, 0);
    chk("rst m_trunc", m_trunc, 0);
    s_valid = 0;
    repeat (2) @(negedge clk);
    r_n = 1;
    @(negedge clk);

    // Table vectors: result fields plus latency from last handshake.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        send_pair(tbl[i].a[k], tbl[i].b[k], k == tbl[i].n-1, tbl[i].gap[k]);
      // Handshake edge already passed; m_valid rises on the following edge.
      n = 0;
      while (!m_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("vec%0d latency", i), n, 1);
      get_result($sformatf("vec%0d", i), tbl[i].acc, tbl[i].of, tbl[i].len, 0);
    end

    // Result back-pressure: outputs held, no pair accepted while stalled.
    m_ready = 0;
    for (int k = 0; k < 4; k++) send_pair(tbl[0].a[k], tbl[0].b[k], k == 3, 0);
    n = 0;
    while (!m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    s_a = 8'd2; s_b = 8'd3; s_last = 1; s_valid = 1;
    seen = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!(m_valid && m_acc == 16'd116 && m_len == LW'(4) && !s_ready && mac_a == 0))
        seen = 0;
    end
    chk("stall hold", seen, 1);
    m_ready = 1;
    send_pair(2, 3, 1, 0);
    get_result("stall first", 116, 0, 4, 0);
    get_result("stall next", 6, 0, 1, 0);

    // Force-termination at MAX_LEN, remaining pairs start the next vector.
    for (int k = 0; k < 20; k++) send_pair(1, 1, 0, 0);
    send_pair(1, 1, 1, 0);
    get_result("maxlen", 16, 0, 16, 1);
    get_result("after maxlen", 5, 0, 5, 0);

    // Reset asserted while the third pair is on the bus.
    send_pair(6, 9, 0, 0);
    send_pair(5, 4, 0, 0);
    s_a = 8'd9; s_b = 8'd2; s_valid = 1;
    r_n = 0;
    #1;
    chk("abort mac_r", mac_r, 1);
    chk("abort s_ready", s_ready, 0);
    chk("abort m_valid", m_valid, 0);
    @(negedge clk);
    @(negedge clk);
    s_valid = 0;
    r_n = 1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    chk("abort no result", seen, 0);
    chk("abort queue", rq.size(), 0);
    send_pair(2, 3, 1, 0);
    get_result("after abort", 6, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule
